// File: rtl/dsram_responder.sv
// Data-side SRAM-like responder: one outstanding load/store, fixed-latency
// data_ok response, byte/half/word strobes derived from size and addr[1:0].
module dsram_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic [31:0] rdata,
    output logic        data_ok,
    output logic        data_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state, state_next;
    logic [3:0]              cnt, cnt_next;
    logic                    accept;
    logic                    err_req;
    logic [3:0]              strb;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [31:0]             mem [DEPTH];
    logic [31:0]             resp_data;
    logic                    resp_err;

    // Upper address bits are dropped, so the array aliases modulo its size.
    assign idx = addr[ADDR_WIDTH+1:2];

    always_comb begin
        strb    = 4'b0000;
        err_req = 1'b0;
        case (size)
            2'd0: strb = 4'b0001 << addr[1:0];
            2'd1: begin
                strb    = addr[1] ? 4'b1100 : 4'b0011;
                err_req = addr[0];
            end
            2'd2: begin
                strb    = 4'b1111;
                err_req = |addr[1:0];
            end
            default: err_req = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        addr_ok    = (state == IDLE) || (state == RESP);
        data_ok    = (state == RESP);
        accept     = req && addr_ok;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(LATENCY - 2);
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_next = RESP;
                else             cnt_next   = cnt - 4'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            resp_data <= 32'd0;
            resp_err  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                resp_err  <= err_req;
                resp_data <= wr ? 32'd0 : mem[idx];
            end
        end
    end

    // Array has no reset; only error-free stores touch it.
    always_ff @(posedge clk) begin
        if (!reset && accept && wr && !err_req) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata    = data_ok ? resp_data : 32'd0;
    assign data_err = data_ok & resp_err;

endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench: one LATENCY=2 instance for function/error/reset cases and
// one LATENCY=1 instance for back-to-back throughput.
module tb_dsram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok, data_err;
    logic [31:0] rdata;

    logic        req1, wr1;
    logic [1:0]  size1;
    logic [31:0] addr1, wdata1;
    logic        addr_ok1, data_ok1, data_err1;
    logic [31:0] rdata1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dsram_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .rdata(rdata),
        .data_ok(data_ok), .data_err(data_err)
    );

    dsram_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req1), .wr(wr1), .size(size1),
        .addr(addr1), .wdata(wdata1), .addr_ok(addr_ok1), .rdata(rdata1),
        .data_ok(data_ok1), .data_err(data_err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request on the LATENCY=2 instance (caller ensures addr_ok)
    // and wait, bounded, for its data_ok.
    task automatic xact(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic e, output int lat);
        req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; wr = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A;
        lat = 1;
        while (!data_ok && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata;
        e  = data_err;
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;

    initial begin
        reset = 1'b1;
        req = 0; wr = 0; size = 2'd2; addr = 0; wdata = 0;
        req1 = 0; wr1 = 0; size1 = 2'd2; addr1 = 0; wdata1 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr_ok", 32'(addr_ok), 32'd1);
        check("rst_data_ok", 32'(data_ok), 32'd0);
        check("rst_data_err", 32'(data_err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Word store then load, accepted back-to-back in the RESP cycle
        xact(1, 2'd2, 32'h100, 32'hDEADBEEF, rd, e, lat);
        check("st_lat", 32'(lat), 32'd2);
        check("st_err", 32'(e), 32'd0);
        check("st_rdata", rd, 32'd0);
        xact(0, 2'd2, 32'h100, 32'h0, rd, e, lat);
        check("ld_lat", 32'(lat), 32'd2);
        check("ld_rdata", rd, 32'hDEADBEEF);
        check("ld_err", 32'(e), 32'd0);

        // Byte and halfword strobes
        xact(1, 2'd2, 32'h40, 32'h11223344, rd, e, lat);
        xact(1, 2'd0, 32'h41, 32'hAAAAAAAA, rd, e, lat);
        check("byte_err", 32'(e), 32'd0);
        xact(1, 2'd1, 32'h42, 32'hBBBBBBBB, rd, e, lat);
        check("half_err", 32'(e), 32'd0);
        xact(0, 2'd2, 32'h40, 32'h0, rd, e, lat);
        check("strobe_rdata", rd, 32'hBBBBAA44);

        // Misaligned and reserved-size requests
        xact(1, 2'd2, 32'h44, 32'h12345678, rd, e, lat);
        xact(1, 2'd2, 32'h45, 32'hFFFFFFFF, rd, e, lat);
        check("mis_word_err", 32'(e), 32'd1);
        check("mis_word_lat", 32'(lat), 32'd2);
        xact(1, 2'd1, 32'h45, 32'hEEEEEEEE, rd, e, lat);
        check("mis_half_err", 32'(e), 32'd1);
        xact(0, 2'd2, 32'h44, 32'h0, rd, e, lat);
        check("mis_unchanged", rd, 32'h12345678);
        check("mis_ld_err", 32'(e), 32'd0);
        xact(0, 2'd3, 32'h44, 32'h0, rd, e, lat);
        check("size3_err", 32'(e), 32'd1);
        check("size3_rdata", rd, 32'h12345678);
        @(posedge clk); #1;
        check("single_pulse", 32'(data_ok), 32'd0);

        // Address wrap modulo 1024 words
        xact(1, 2'd2, 32'h1000, 32'h5, rd, e, lat);
        xact(0, 2'd2, 32'h0, 32'h0, rd, e, lat);
        check("wrap_rdata", rd, 32'h5);

        // Reset in the WAIT cycle drops the response but keeps the store
        @(posedge clk); #1;
        req = 1; wr = 1; size = 2'd2; addr = 32'h200; wdata = 32'h77;
        @(posedge clk); #1;
        req = 0; wr = 0;
        check("wait_addr_ok", 32'(addr_ok), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_data_ok", 32'(data_ok), 32'd0);
        check("rst_mid_addr_ok", 32'(addr_ok), 32'd1);
        @(posedge clk); #1;
        check("rst_mid_data_ok2", 32'(data_ok), 32'd0);
        xact(0, 2'd2, 32'h200, 32'h0, rd, e, lat);
        check("rst_mid_rdata", rd, 32'h77);

        // Back-to-back on the LATENCY=1 instance: 4 stores then 4 loads
        for (int i = 0; i < 8; i++) begin
            req1 = 1'b1;
            wr1 = (i < 4);
            size1 = 2'd2;
            addr1 = 32'((i % 4) * 4 + 32'h300);
            wdata1 = 32'hA0 + 32'(i);
            check($sformatf("b2b_addr_ok%0d", i), 32'(addr_ok1), 32'd1);
            @(posedge clk); #1;
            check($sformatf("b2b_data_ok%0d", i), 32'(data_ok1), 32'd1);
            if (i >= 4)
                check($sformatf("b2b_rdata%0d", i), rdata1, 32'hA0 + 32'(i - 4));
        end
        req1 = 1'b0;
        @(posedge clk); #1;
        check("b2b_done", 32'(data_ok1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsram_responder.md
# dsram_responder

Data-side SRAM-like responder serving the memory stage's load/store requests from a synchronous word array. It accepts one request at a time over a req/addr_ok address phase and returns a data_ok pulse, with read data, a fixed, parameterised number of cycles later. Byte and halfword stores use strobes generated internally from size and the address low bits. Read data is always the full aligned word; the memory stage does any byte/half extraction.

## Interface

Parameters:
- ADDR_WIDTH, 10, number of word-address bits; array depth is 2^ADDR_WIDTH words.
- LATENCY, 2, cycles from request acceptance to data_ok; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request valid; held by the requester until accepted.
- wr  input  1  1 = store, 0 = load.
- size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is reserved.
- addr  input  32  byte address.
- wdata  input  32  store data, already lane-replicated by the requester.
- addr_ok  output  1  address phase accepted when req && addr_ok are both high in a cycle.
- rdata  output  32  aligned word; valid only while data_ok is high.
- data_ok  output  1  one-cycle response pulse for the accepted request (loads and stores).
- data_err  output  1  high together with data_ok when the request was misaligned or size==3.

## Operation

- States:
  - IDLE: no request outstanding.
  - WAIT: accepted, counting down.
  - RESP: data_ok cycle.
- addr_ok = (state==IDLE) || (state==RESP). This allows back-to-back requests, so a new request can be accepted in the same cycle data_ok is high.
- On acceptance (edge ending cycle A):
  - Latch wr and the error flag.
  - Word index = addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo the array size.
  - Store, no error: write the selected lanes of wdata into the array at the acceptance edge.
  - Load: capture array[index] into a response register at the acceptance edge. A load therefore sees every store accepted before it.
  - If LATENCY==1, go to RESP; otherwise load the counter with LATENCY-2 and go to WAIT.
- WAIT: the counter decrements each cycle. When it is 0, go to RESP on the next edge.
- RESP:
  - data_ok=1 and rdata = response register (0 for stores); data_err = latched flag.
  - Next state is WAIT/RESP if a new request is accepted this cycle (same rules as IDLE), otherwise IDLE.
- Strobes:
  - Byte: lane addr[1:0].
  - Halfword: lanes {addr[1],0} and {addr[1],1}; requires addr[0]==0.
  - Word: all four lanes; requires addr[1:0]==00.
- Errors (misaligned request or size==3):
  - The array is not written.
  - The request still completes with normal latency, with data_err=1 and the read data returned unchanged.
- The array is not reset; its contents are undefined until written.

## Timing

- Reset values: state=IDLE, addr_ok=1, data_ok=0, data_err=0, rdata=0.
- Request accepted in cycle A gives data_ok=1 exactly in cycle A+LATENCY. data_ok is never high for two consecutive cycles from a single request.
- Maximum throughput is one request per LATENCY cycles.
- req is ignored while addr_ok=0. Inputs are sampled only in the acceptance cycle, so later changes have no effect on the outstanding request.
- Reset asserted mid-operation:
  - The outstanding response is dropped, and data_ok stays 0 in the cycle after the reset edge.
  - A store already committed at its acceptance edge remains in the array.

## Test plan

- Word write then read, LATENCY=2:
  - Store 0xDEADBEEF to 0x100 accepted in cycle 0 -> data_ok in cycle 2, data_err=0.
  - Load 0x100 accepted in cycle 2 -> data_ok in cycle 4 with rdata=0xDEADBEEF.
- Byte and halfword strobes:
  - Word 0x11223344 at 0x40.
  - Byte store of 0xAAAAAAAA at 0x41.
  - Half store of 0xBBBBBBBB at 0x42.
  - Load 0x40 -> rdata=0xBBBBAA44.
- Misaligned store: word store of 0xFFFFFFFF at 0x45 -> data_ok with data_err=1; a later load of 0x44 returns the prior contents unchanged.
- Back-to-back, LATENCY=1, req held high for 4 addresses -> 4 data_ok pulses in 4 consecutive cycles, addr_ok continuously high.
- Address wrap, ADDR_WIDTH=10: store 0x5 to 0x1000 -> load of 0x0 returns 0x5.
- Reset mid-op: store 0x77 accepted, reset in the WAIT cycle -> no data_ok; after reset, state IDLE with addr_ok=1, and a load of that address returns 0x77.
